// File: rtl/nand_pkg.sv
// Shared definitions for the NAND sweep controller.
// Holds the FSM state encoding and the golden NAND reference.
package nand_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DRIVE,
      S_SETTLE,
      S_SAMPLE,
      S_DONE
   } state_t;

   localparam int MAX_IN = 16;

   function automatic logic golden_nand(
      input logic [MAX_IN-1:0] v,
      input int                n
   );
      logic a;
      a = 1'b1;
      for (int i = 0; i < MAX_IN; i++)
         if (i < n) a = a & v[i];
      return ~a;
   endfunction

endpackage

// File: rtl/nand_sweep_ctrl_if.sv
// Stimulus/response bundle between the sweep controller
// and the gate instances under test.
interface nand_sweep_ctrl_if #(
   parameter int N_IN   = 2,
   parameter int N_IMPL = 3,
   parameter int ERR_W  = 8
);
   logic              start;
   logic              abort;
   logic [N_IN-1:0]   vec_o;
   logic [N_IMPL-1:0] dut_c_i;
   logic              busy;
   logic              done;
   logic              pass;
   logic [ERR_W-1:0]  err_cnt;
   logic [N_IN-1:0]   fail_vec;
   logic [N_IMPL-1:0] fail_mask;

   modport master (
      output start, abort, dut_c_i,
      input  vec_o, busy, done, pass,
      input  err_cnt, fail_vec, fail_mask
   );

   modport slave (
      input  start, abort, dut_c_i,
      output vec_o, busy, done, pass,
      output err_cnt, fail_vec, fail_mask
   );
endinterface

// File: rtl/popcount_sat.sv
// Adds the mismatch popcount to the error counter,
// clamping at the counter's all-ones value.
module popcount_sat #(
   parameter int N = 3,
   parameter int W = 8
) (
   input  logic [W-1:0] cnt,
   input  logic [N-1:0] mism,
   output logic [W-1:0] nxt
);
   localparam int SW = W + $clog2(N + 1);

   // Wide enough that several adds near the top cannot wrap.
   logic [SW-1:0] sum;

   always_comb begin
      sum = SW'(cnt);
      for (int i = 0; i < N; i++)
         sum = sum + SW'(mism[i]);
      if (sum > SW'({W{1'b1}}))
         nxt = {W{1'b1}};
      else
         nxt = sum[W-1:0];
   end
endmodule

// File: rtl/nand_sweep_ctrl.sv
// Sweeps every input vector through all NAND variants,
// counts mismatches against a golden NAND, keeps first failure.
module nand_sweep_ctrl
   import nand_pkg::*;
#(
   parameter int N_IN       = 2,
   parameter int N_IMPL     = 3,
   parameter int SETTLE_CYC = 4,
   parameter int ERR_W      = 8
) (
   input logic              clk,
   input logic              rst_n,
   nand_sweep_ctrl_if.slave bus
);
   state_t            state;
   logic [7:0]        cnt;
   logic              first_seen;
   logic              golden;
   logic [N_IMPL-1:0] mism;
   logic [ERR_W-1:0]  err_nxt;

   assign golden = golden_nand(MAX_IN'(bus.vec_o), N_IN);
   assign mism   = bus.dut_c_i ^ {N_IMPL{golden}};

   popcount_sat #(
      .N (N_IMPL),
      .W (ERR_W)
   ) u_sat (
      .cnt  (bus.err_cnt),
      .mism (mism),
      .nxt  (err_nxt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         cnt           <= '0;
         first_seen    <= 1'b0;
         bus.vec_o     <= '0;
         bus.busy      <= 1'b0;
         bus.done      <= 1'b0;
         bus.pass      <= 1'b0;
         bus.err_cnt   <= '0;
         bus.fail_vec  <= '0;
         bus.fail_mask <= '0;
      end else begin
         bus.done <= 1'b0;
         // Abort beats start even when both arrive in IDLE/DONE.
         if (bus.abort) begin
            state    <= S_IDLE;
            bus.busy <= 1'b0;
            bus.pass <= 1'b0;
         end else begin
            unique case (state)
               S_IDLE, S_DONE: begin
                  if (bus.start) begin
                     state         <= S_DRIVE;
                     bus.busy      <= 1'b1;
                     bus.pass      <= 1'b0;
                     bus.vec_o     <= '0;
                     bus.err_cnt   <= '0;
                     bus.fail_vec  <= '0;
                     bus.fail_mask <= '0;
                     first_seen    <= 1'b0;
                  end
               end
               S_DRIVE: begin
                  if (SETTLE_CYC == 0) begin
                     state <= S_SAMPLE;
                  end else begin
                     cnt   <= 8'(SETTLE_CYC - 1);
                     state <= S_SETTLE;
                  end
               end
               S_SETTLE: begin
                  if (cnt == '0) state <= S_SAMPLE;
                  else           cnt   <= cnt - 8'd1;
               end
               S_SAMPLE: begin
                  bus.err_cnt <= err_nxt;
                  if (mism != '0 && !first_seen) begin
                     bus.fail_vec  <= bus.vec_o;
                     bus.fail_mask <= mism;
                     first_seen    <= 1'b1;
                  end
                  if (bus.vec_o == '1) begin
                     state    <= S_DONE;
                     bus.done <= 1'b1;
                     bus.busy <= 1'b0;
                     bus.pass <= (err_nxt == '0);
                  end else begin
                     bus.vec_o <= bus.vec_o + 1'b1;
                     state     <= S_DRIVE;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_nand_sweep_ctrl.sv
// Scoreboarded bench: stimulus queues expected sweep results,
// monitors pop and compare on every done pulse.
module tb_nand_sweep_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   typedef struct {
      int err;
      int fv;
      int fm;
      int pass;
      int dc;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   exp_t ea, eb, e;
   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int mode_a = 0;
   int mode_b = 0;

   always @(posedge clk) cyc <= cyc + 1;

   nand_sweep_ctrl_if #(.N_IN(2), .N_IMPL(3), .ERR_W(8)) ia ();
   nand_sweep_ctrl_if #(.N_IN(2), .N_IMPL(3), .ERR_W(2)) ib ();

   nand_sweep_ctrl #(
      .N_IN(2), .N_IMPL(3), .SETTLE_CYC(4), .ERR_W(8)
   ) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ia.slave)
   );

   nand_sweep_ctrl #(
      .N_IN(2), .N_IMPL(3), .SETTLE_CYC(0), .ERR_W(2)
   ) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ib.slave)
   );

   // Gate models: 0 good, 1 bit2 is AND, 2 bit0 stuck-1, 3 all inverted
   function automatic logic [2:0] impl(input int m, input logic [1:0] v);
      logic g;
      g = ~&v;
      case (m)
         1:       return {&v, g, g};
         2:       return {g, g, 1'b1};
         3:       return {~g, ~g, ~g};
         default: return {g, g, g};
      endcase
   endfunction

   assign ia.dut_c_i = impl(mode_a, ia.vec_o);
   assign ib.dut_c_i = impl(mode_b, ib.vec_o);

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (ia.done === 1'b1) begin
         if (qa.size() == 0) begin
            chk("a_unexpected_done", 1, 0);
         end else begin
            ea = qa.pop_front();
            chk("a_err_cnt", int'(ia.err_cnt), ea.err);
            chk("a_fail_vec", int'(ia.fail_vec), ea.fv);
            chk("a_fail_mask", int'(ia.fail_mask), ea.fm);
            chk("a_pass", int'(ia.pass), ea.pass);
            chk("a_busy_done", int'(ia.busy), 0);
            chk("a_done_cyc", cyc, ea.dc);
         end
      end
   end

   always @(negedge clk) begin
      if (ib.done === 1'b1) begin
         if (qb.size() == 0) begin
            chk("b_unexpected_done", 1, 0);
         end else begin
            eb = qb.pop_front();
            chk("b_err_cnt", int'(ib.err_cnt), eb.err);
            chk("b_fail_vec", int'(ib.fail_vec), eb.fv);
            chk("b_fail_mask", int'(ib.fail_mask), eb.fm);
            chk("b_pass", int'(ib.pass), eb.pass);
            chk("b_busy_done", int'(ib.busy), 0);
            chk("b_done_cyc", cyc, eb.dc);
         end
      end
   end

   task automatic start_a(input bit push, input exp_t x, input int lat);
      @(negedge clk);
      ia.start = 1'b1;
      @(posedge clk);
      #1;
      ia.start = 1'b0;
      x.dc = cyc + lat;
      if (push) qa.push_back(x);
   endtask

   task automatic wait_done(input bit b, input string nm);
      int k;
      k = 0;
      while ((b ? ib.done : ia.done) !== 1'b1 && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk(nm, int'((b ? ib.done : ia.done) === 1'b1), 1);
   endtask

   task automatic wait_vec_a(input int v);
      int k;
      k = 0;
      while (int'(ia.vec_o) != v && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk("a_wait_vec", int'(ia.vec_o), v);
   endtask

   initial begin
      rst_n    = 1'b0;
      ia.start = 1'b0;
      ia.abort = 1'b0;
      ib.start = 1'b0;
      ib.abort = 1'b0;
      #22;
      chk("rst_vec", int'(ia.vec_o), 0);
      chk("rst_busy", int'(ia.busy), 0);
      chk("rst_done", int'(ia.done), 0);
      chk("rst_pass", int'(ia.pass), 0);
      chk("rst_err", int'(ia.err_cnt), 0);
      chk("rst_fmask", int'(ia.fail_mask), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Good gates: vector sequence 0..3, 6 cycles each
      mode_a = 0;
      e = '{err: 0, fv: 0, fm: 0, pass: 1, dc: 0};
      start_a(1'b1, e, 24);
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         chk("a_vec_seq", int'(ia.vec_o), i / 6);
         chk("a_busy_seq", int'(ia.busy), 1);
      end
      wait_done(1'b0, "a_good_done");

      mode_a = 1;
      e = '{err: 4, fv: 0, fm: 4, pass: 0, dc: 0};
      start_a(1'b1, e, 24);
      wait_done(1'b0, "a_and_done");

      mode_a = 2;
      e = '{err: 1, fv: 3, fm: 1, pass: 0, dc: 0};
      start_a(1'b1, e, 24);
      wait_done(1'b0, "a_stuck_done");

      // Abort in SETTLE of vector 2; vectors 0 and 1 already counted
      mode_a = 1;
      start_a(1'b0, e, 24);
      wait_vec_a(2);
      @(negedge clk);
      ia.abort = 1'b1;
      @(posedge clk);
      #1;
      ia.abort = 1'b0;
      chk("abort_busy", int'(ia.busy), 0);
      chk("abort_done", int'(ia.done), 0);
      chk("abort_pass", int'(ia.pass), 0);
      chk("abort_err", int'(ia.err_cnt), 2);
      chk("abort_fmask", int'(ia.fail_mask), 4);
      repeat (10) @(negedge clk);
      chk("abort_idle_busy", int'(ia.busy), 0);
      mode_a = 0;
      e = '{err: 0, fv: 0, fm: 0, pass: 1, dc: 0};
      start_a(1'b1, e, 24);
      wait_done(1'b0, "a_after_abort_done");

      // SETTLE_CYC=0, ERR_W=2, start held into the sweep
      mode_b = 3;
      @(negedge clk);
      ib.start = 1'b1;
      @(posedge clk);
      #1;
      e = '{err: 3, fv: 0, fm: 7, pass: 0, dc: cyc + 8};
      qb.push_back(e);
      repeat (4) @(negedge clk);
      ib.start = 1'b0;
      wait_done(1'b1, "b_sat_done");

      // Re-start straight from DONE must clear saturated results
      mode_b = 0;
      @(negedge clk);
      ib.start = 1'b1;
      @(posedge clk);
      #1;
      ib.start = 1'b0;
      e = '{err: 0, fv: 0, fm: 0, pass: 1, dc: cyc + 8};
      qb.push_back(e);
      wait_done(1'b1, "b_restart_done");

      // Async reset while in SAMPLE of vector 1
      mode_a = 1;
      start_a(1'b0, e, 24);
      wait_vec_a(1);
      repeat (5) @(posedge clk);
      #2;
      chk("pre_rst_err", int'(ia.err_cnt), 1);
      chk("pre_rst_busy", int'(ia.busy), 1);
      rst_n = 1'b0;
      #1;
      chk("async_vec", int'(ia.vec_o), 0);
      chk("async_busy", int'(ia.busy), 0);
      chk("async_err", int'(ia.err_cnt), 0);
      chk("async_fmask", int'(ia.fail_mask), 0);
      chk("async_b_pass", int'(ib.pass), 0);
      #1;
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("q_a_empty", qa.size(), 0);
      chk("q_b_empty", qb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
